// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size encodings, FSM states and helpers for the load/store unit.
package lsu_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;
  typedef enum logic [2:0] {IDLE, READ, WRITE, RESP, ERR} state_t;
  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction
endpackage

// File: rtl/lsu_ram.sv
// lsu_ram: word-wide data memory with full-word write and registered read address.
module lsu_ram #(
  parameter int DW = 32,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata
);
  logic [DW-1:0] mem [DEPTH];
  logic [$clog2(DEPTH)-1:0] raddr;
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    raddr <= addr;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/lsu_mem.sv
// lsu_mem: single-request load/store unit with byte lanes, RMW partial stores and wait states.
module lsu_mem
  import lsu_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 10,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err
);
  localparam int OB = $clog2(DW/8);
  localparam int WAW = AW - OB;
  state_t state;
  logic [1:0] cnt, size_q;
  logic we_q, sgn_q, bad_in, full_in, last;
  logic [OB-1:0] off_in, off_q;
  logic [WAW-1:0] widx_q;
  logic [DW-1:0] wdata_q, rd_q, ram_rdata, lmask, bmask, sh, ext, wmerge;
  assign off_in = req_addr[OB-1:0];
  assign bad_in = (req_size == SZ_DWORD && DW == 32) || (off_in & OB'(size_bytes(req_size) - 4'd1)) != '0;
  assign full_in = req_we && size_bytes(req_size) == 4'(DW/8);
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP || state == ERR;
  assign last = cnt == 2'(RD_LAT - 1);
  // lmask covers the access width at bit 0; shifting past DW yields all ones for full-width
  assign lmask = ~({DW{1'b1}} << {size_bytes(size_q), 3'b000});
  assign sh = ram_rdata >> {off_q, 3'b000};
  assign ext = (sh & lmask) | ((sgn_q && |(sh & (lmask ^ (lmask >> 1)))) ? ~lmask : '0);
  assign bmask = lmask << {off_q, 3'b000};
  assign wmerge = (rd_q & ~bmask) | ((wdata_q << {off_q, 3'b000}) & bmask);
  // Present the incoming address while idle so read data is ready in the first READ cycle
  lsu_ram #(.DW(DW), .DEPTH(2**WAW)) u_ram (
    .clk(clk),
    .we(state == WRITE && rst),
    .addr(req_ready ? req_addr[AW-1:OB] : widx_q),
    .wdata(wmerge),
    .rdata(ram_rdata)
  );
  always_ff @(posedge clk) begin
    if (req_valid && req_ready) begin
      we_q <= req_we;
      size_q <= req_size;
      sgn_q <= req_signed;
      off_q <= off_in;
      widx_q <= req_addr[AW-1:OB];
      wdata_q <= req_wdata;
    end
    if (state == READ) rd_q <= ram_rdata;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          state <= bad_in ? ERR : full_in ? WRITE : READ;
          rsp_err <= bad_in;
        end
        READ: begin
          cnt <= last ? '0 : cnt + 2'd1;
          if (last) state <= we_q ? WRITE : RESP;
          if (last && !we_q) rsp_rdata <= ext;
        end
        WRITE: state <= RESP;
        default: if (rsp_ready) begin
          state <= IDLE;
          rsp_rdata <= '0;
          rsp_err <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem.sv
// tb_lsu_mem: directed and random checks of two lsu_mem instances (32-bit/RD_LAT=1, 64-bit/RD_LAT=3) against a byte-array model.
module tb_lsu_mem;
  logic clk = 1'b0;
  logic rst, req_valid, req_we, req_signed, rsp_ready, sel;
  logic [1:0] req_size;
  logic [9:0] req_addr;
  logic [63:0] req_wdata;
  logic a_ready, a_rvalid, a_err, b_ready, b_rvalid, b_err;
  logic [31:0] a_rdata;
  logic [63:0] b_rdata;
  logic ready, rvalid, err;
  logic [63:0] rdata;
  logic [7:0] ma [1024];
  logic [7:0] mb [1024];
  int checks = 0, failures = 0, got_lat;
  logic [63:0] got_rd;

  always #5 clk = ~clk;

  assign ready = sel ? b_ready : a_ready;
  assign rvalid = sel ? b_rvalid : a_rvalid;
  assign err = sel ? b_err : a_err;
  assign rdata = sel ? b_rdata : {32'b0, a_rdata};

  lsu_mem #(.DW(32), .AW(10), .RD_LAT(1)) u_a (
    .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(a_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata[31:0]), .rsp_valid(a_rvalid), .rsp_ready(rsp_ready & ~sel),
    .rsp_rdata(a_rdata), .rsp_err(a_err)
  );
  lsu_mem #(.DW(64), .AW(10), .RD_LAT(3)) u_b (
    .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(b_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(b_rvalid), .rsp_ready(rsp_ready & sel),
    .rsp_rdata(b_rdata), .rsp_err(b_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model(input bit b, input bit we, input logic [1:0] size, input bit sgn,
                                input logic [9:0] addr, input logic [63:0] wd,
                                output logic [63:0] rd, output bit e);
    int nb = 1 << size;
    logic [63:0] v = '0;
    rd = '0;
    e = (size == 2'b11 && !b) || (int'(addr) % nb != 0);
    if (e) return;
    for (int i = 0; i < nb; i++) begin
      if (we && b) mb[int'(addr) + i] = wd[8*i +: 8];
      else if (we) ma[int'(addr) + i] = wd[8*i +: 8];
      else v[8*i +: 8] = b ? mb[int'(addr) + i] : ma[int'(addr) + i];
    end
    if (!we) begin
      if (sgn && v[8*nb-1]) v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8*nb));
      rd = b ? v : {32'b0, v[31:0]};
    end
  endfunction

  task automatic xact(input bit b, input bit we, input logic [1:0] size, input bit sgn,
                      input logic [9:0] addr, input logic [63:0] wd, input int hold);
    logic [63:0] erd;
    bit eerr;
    int nb, elat, rl;
    model(b, we, size, sgn, addr, wd, erd, eerr);
    nb = 1 << size;
    rl = b ? 3 : 1;
    elat = eerr ? 1 : (we && nb == (b ? 8 : 4)) ? 2 : we ? 2 + rl : 1 + rl;
    sel = b; req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    #0 chk("req_ready_idle", ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    got_lat = 1;
    while (!rvalid && got_lat < 20) begin
      @(posedge clk); #1;
      got_lat++;
    end
    chk("latency", got_lat, elat);
    chk("rsp_err", err, eerr);
    chk("rsp_rdata", rdata, erd);
    got_rd = rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", rvalid, 1);
      chk("hold_rdata", rdata, erd);
      chk("hold_req_ready", ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("idle_after_rsp", ready, 1);
    chk("valid_after_rsp", rvalid, 0);
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_signed = 1'b0; rsp_ready = 1'b0;
    sel = 1'b0; req_size = 2'b00; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #0;
      chk("reset_ready", ready, 1);
      chk("reset_valid", rvalid, 0);
      chk("reset_rdata", rdata, 0);
      chk("reset_err", err, 0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    xact(0, 1, 2'b10, 0, 10'h10, 64'hDEADBEEF, 0);
    xact(0, 0, 2'b10, 1, 10'h10, 0, 0);
    chk("load_word", got_rd, 64'hDEADBEEF);
    xact(0, 1, 2'b00, 0, 10'h11, 64'h80, 0);
    xact(0, 0, 2'b10, 0, 10'h10, 0, 0);
    chk("merge_byte", got_rd, 64'hDEAD80EF);
    xact(0, 0, 2'b00, 1, 10'h11, 0, 0);
    chk("lb_signed", got_rd, 64'hFFFFFF80);
    xact(0, 0, 2'b00, 0, 10'h11, 0, 0);
    chk("lb_unsigned", got_rd, 64'h80);
    xact(0, 0, 2'b01, 0, 10'h13, 0, 0);
    chk("misalign_lat", got_lat, 1);
    xact(0, 1, 2'b01, 0, 10'h13, 64'hFFFF, 0);
    xact(0, 0, 2'b10, 0, 10'h10, 0, 0);
    chk("misalign_nowrite", got_rd, 64'hDEAD80EF);
    xact(0, 0, 2'b11, 0, 10'h10, 0, 0);
    xact(1, 1, 2'b11, 0, 10'h8, 64'h0123456789ABCDEF, 0);
    chk("full_store_lat", got_lat, 2);
    xact(1, 0, 2'b01, 0, 10'hE, 0, 0);
    chk("lh_dword", got_rd, 64'h0123);
    chk("load_lat", got_lat, 4);
    xact(1, 1, 2'b00, 0, 10'h9, 64'h5A, 0);
    chk("partial_lat", got_lat, 5);
    xact(1, 0, 2'b11, 0, 10'h8, 0, 0);
    chk("dword_merge", got_rd, 64'h0123456789AB5AEF);
    for (int a = 0; a < 256; a += 4) xact(0, 1, 2'b10, 0, 10'(a), {32'b0, $urandom}, 0);
    for (int a = 0; a < 256; a += 8) xact(1, 1, 2'b11, 0, 10'(a), {$urandom, $urandom}, 0);
    repeat (120)
      xact($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
           $urandom_range(0, 1) == 1, 10'($urandom_range(0, 255)), {$urandom, $urandom}, 0);
    xact(0, 0, 2'b10, 0, 10'h10, 0, 10);
    xact(1, 0, 2'b11, 1, 10'h18, 0, 3);
    xact(0, 1, 2'b10, 0, 10'h20, 64'h11111111, 0);
    sel = 1'b0; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 10'h20;
    req_wdata = 64'hAA; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready", ready, 1);
    chk("rst_valid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", err, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    xact(0, 0, 2'b10, 0, 10'h20, 0, 0);
    chk("rst_no_write", got_rd, 64'h11111111);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lsu_mem.md
# lsu_mem

Parametrised load/store unit with embedded byte-addressable data memory, the next-generation replacement for the fixed 1 KB word memory plus ad-hoc store-byte merge in the multicycle MIPS datapath. It accepts one load or store request at a time over a valid/ready handshake and supports byte, half, word and (at 64-bit width) doubleword accesses. Partial stores use an internal read-modify-write sequence, and loads apply sign or zero extension. Misaligned accesses are flagged without touching memory. Configurable wait states model slower memory. It sits between the ALU address register and the register write-back mux.

## Interface
Parameters:
- DW, 32, data width in bits; legal values 32 or 64.
- AW, 10, byte address width; memory depth = 2**AW bytes = 2**(AW - log2(DW/8)) words.
- RD_LAT, 1, read wait states, 1..4; memory read data is valid RD_LAT cycles after the read starts.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous assertion, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high exactly when the FSM is in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 doubleword (legal only when DW=64).
- req_signed  in  1  load sign-extends when 1 and zero-extends when 0; ignored for stores.
- req_addr  in  AW  byte address.
- req_wdata  in  DW  store data, right-aligned (the low bytes are used).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  DW  load result, extended to DW; 0 for stores and errors.
- rsp_err  out  1  misaligned access or illegal size; qualified by rsp_valid.

## Operation
- Byte order is little-endian. Lane offset = req_addr[log2(DW/8)-1:0]. Word index = req_addr[AW-1:log2(DW/8)].
- Alignment rules:
  - An access is aligned when the offset is a multiple of the access size in bytes.
  - Size 11 with DW=32 is illegal.
  - A misaligned or illegal request causes no memory access and produces rsp_err=1, rsp_rdata=0.
- All request fields are captured in internal registers on acceptance (req_valid && req_ready). Inputs are don't-care afterwards.
- FSM states and transitions:
  - IDLE: on accept, go to ERR if misaligned/illegal; to WRITE if a full-width store; otherwise to READ.
  - READ: wait-state counter runs 0..RD_LAT-1. At RD_LAT-1, go to RESP for a load, or to WRITE for a partial store.
  - WRITE: memory word is written at the end of this cycle. For a partial store, the captured read word is merged with the selected lanes of the captured wdata. Go to RESP.
  - ERR and RESP: rsp_valid=1. Stay until rsp_ready=1, then go to IDLE.
- Load extraction: take the selected lanes, shift them to bit 0, then extend using the sign bit when req_signed=1, else with zeros.
- rsp_rdata and rsp_err are registered and stable for as long as rsp_valid is high.
- No back-to-back acceptance: the cycle after a response handshake is always IDLE.

## Timing
- Request accepted in cycle k. Response latencies:
  - Error: rsp_valid first in cycle k+1.
  - Full-width store: WRITE in k+1, rsp_valid in k+2.
  - Load: READ k+1..k+RD_LAT, rsp_valid in k+1+RD_LAT.
  - Partial store: READ k+1..k+RD_LAT, WRITE in k+1+RD_LAT, rsp_valid in k+2+RD_LAT.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter 0. Memory contents are not reset.
- Reset mid-operation: the in-flight request is dropped. The memory write enable is gated by rst, so no write occurs while rst is low, even if reset is asserted during WRITE.
- Backpressure: if rsp_ready stays low, rsp_valid and the response data hold indefinitely, and req_ready stays low.

## Structure
- Package lsu_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD;
  - state enum IDLE, READ, WRITE, RESP, ERR;
  - function size_bytes(size).
- Sub-module lsu_ram (parameters DW, depth):
  - word array;
  - synchronous write with full-word enable;
  - registered read address, one-cycle read.
- The lsu_mem FSM supplies the additional RD_LAT-1 wait cycles by holding the address stable during READ.
- Top level contains the FSM, capture registers, lane merge and extract logic, and the alignment checker.

## Test plan
- DW=32, RD_LAT=1:
  - Store word 0xDEADBEEF @0x10, then load word signed @0x10 → rsp_rdata=0xDEADBEEF, rsp_err=0.
  - Store byte 0x80 @0x11, then load word @0x10 → 0xDEAD80EF.
  - Load byte signed @0x11 → 0xFFFFFF80; unsigned → 0x00000080.
- Misaligned: load half @0x13 → rsp_err=1 and rsp_rdata=0 in cycle k+1; a subsequent word load @0x10 shows memory unchanged.
- DW=32, size 11 → rsp_err=1.
- DW=64: store dword 0x0123456789ABCDEF @0x8, then load half unsigned @0xE → 0x0123.
- RD_LAT=3 latency check:
  - load rsp_valid exactly 4 cycles after accept;
  - partial store 5 cycles;
  - full store 2 cycles.
- Backpressure and reset:
  - Hold rsp_ready=0 for 10 cycles → response stable and req_ready=0 throughout.
  - Assert rst during WRITE of a partial store to @0x20 (previously 0x11111111) → after reset, word load @0x20 = 0x11111111 and all outputs are at their reset values.
